psum_accum: RTL

PSUM_ACCUM -- requirements
Module: psum_accum

---
 rtl/cnn_pkg.sv | 14 +
 rtl/psum_requant.sv | 41 ++++
 rtl/psum_accum.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and FSM state type for the CNN partial-sum datapath.
package cnn_pkg;

    localparam int PSUM_W = 25;
    localparam int ACC_W  = 32;
    localparam int OUT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } accum_state_t;

endpackage

// File: rtl/psum_requant.sv
// Combinational requantizer: round-half-up arithmetic shift, saturate to int8,
// optional ReLU when PSUM_ACCUM_RELU_EN is defined.
module psum_requant
    import cnn_pkg::*;
#(
    parameter int ACC_W = cnn_pkg::ACC_W
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic        [4:0]       shift,
    output logic signed [OUT_W-1:0] q
);

    localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'(127);
    localparam logic signed [ACC_W:0] Q_MIN = -(ACC_W+1)'(128);

    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] biased;
    logic signed [ACC_W:0] shifted;

    always_comb begin
        rnd = '0;
        if (shift != 5'd0)
            rnd = (ACC_W+1)'(1) << (shift - 5'd1);
        // one extra bit so the rounding term cannot wrap near the max value
        biased  = {acc[ACC_W-1], acc} + rnd;
        shifted = biased >>> shift;

        if (shifted > Q_MAX)
            q = 8'sd127;
        else if (shifted < Q_MIN)
            q = -8'sd128;
        else
            q = $signed(shifted[OUT_W-1:0]);

`ifdef PSUM_ACCUM_RELU_EN
        if (q < 0)
            q = '0;
`endif
    end

endmodule

// File: rtl/psum_accum.sv
// Partial-sum accumulator: sums cfg_len signed psums onto a bias, then emits an
// int8 activation. Build option PSUM_ACCUM_RELU_EN clamps negative outputs to 0.
module psum_accum #(
    parameter int PSUM_W = 25,
    parameter int ACC_W  = 32,
    parameter int LEN_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic        [LEN_W-1:0]  cfg_len,
    input  logic signed [15:0]       cfg_bias,
    input  logic        [4:0]        cfg_shift,
    input  logic                     psum_valid,
    input  logic signed [PSUM_W-1:0] psum_in,
    output logic                     psum_ready,
    output logic                     out_valid,
    output logic signed [7:0]        out_data,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     sat_flag
);
    import cnn_pkg::*;

    localparam logic [LEN_W-1:0]        ONE     = LEN_W'(1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    accum_state_t             state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic        [LEN_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic        [LEN_W-1:0]  len_q, len_d;
    logic        [4:0]        shift_q, shift_d;
    logic signed [15:0]       bias_q, bias_d;
    logic                     sat_q, sat_d;
    logic signed [7:0]        out_data_q;
    logic signed [OUT_W-1:0]  rq_out;

    logic                     accept, first;
    logic signed [ACC_W-1:0]  add_a, add_b, sum_sat;
    logic        [ACC_W:0]    sum_w;
    logic                     ovf;

    assign psum_ready = (state_q != ST_EMIT);
    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = (state_q == ST_EMIT);
    assign out_data   = out_data_q;
    assign sat_flag   = sat_q;

    assign accept  = psum_valid && psum_ready;
    assign first   = accept && (state_q == ST_IDLE);
    assign cnt_inc = cnt_q + ONE;

    // Config is captured only on the first beat; later edits wait for the next group.
    always_comb begin
        len_d   = len_q;
        shift_d = shift_q;
        bias_d  = bias_q;
        if (first) begin
            len_d   = (cfg_len == '0) ? ONE : cfg_len;
            shift_d = cfg_shift;
            bias_d  = cfg_bias;
        end
    end

    // Saturating add: the first beat starts from the bias, later beats from acc.
    always_comb begin
        add_a   = (state_q == ST_IDLE) ? ACC_W'(bias_d) : acc_q;
        add_b   = ACC_W'(psum_in);
        sum_w   = {add_a[ACC_W-1], add_a} + {add_b[ACC_W-1], add_b};
        ovf     = sum_w[ACC_W] ^ sum_w[ACC_W-1];
        sum_sat = ovf ? (sum_w[ACC_W] ? ACC_MIN : ACC_MAX) : $signed(sum_w[ACC_W-1:0]);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    acc_d   = sum_sat;
                    cnt_d   = ONE;
                    sat_d   = sat_q | ovf;
                    state_d = (len_d == ONE) ? ST_EMIT : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    acc_d = sum_sat;
                    cnt_d = cnt_inc;
                    sat_d = sat_q | ovf;
                    if (cnt_inc == len_q)
                        state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Requantize the value acc is about to take so out_data lands with out_valid.
    psum_requant #(.ACC_W(ACC_W)) u_requant (
        .acc   (acc_d),
        .shift (shift_d),
        .q     (rq_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            shift_q    <= '0;
            bias_q     <= '0;
            sat_q      <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            shift_q <= shift_d;
            bias_q  <= bias_d;
            sat_q   <= sat_d;
            if (state_d == ST_EMIT && state_q != ST_EMIT)
                out_data_q <= 8'(rq_out);
        end
    end

endmodule
